ncc_mem_arbiter: RTL and testbench
==================================

NCC_MEM_ARBITER -- requirements
Module: ncc_mem_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 64: max beats per grant before forced release.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4: max reads issued and not yet returned.
REQ-003 SHALL have port clk  in  1  rising-edge clock; the block uses one clock.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port req  in  3  per-requester request: bit0 template reader, bit1 window reader, bit2 result writer; held high for a whole burst.
REQ-006 SHALL have port req_rd_wr  in  3  per-requester direction: 0 read, 1 write.
REQ-007 SHALL have port req_tem_win  in  3  per-requester region select: 0 template, 1 window.
REQ-008 SHALL have port req_row  in  21  three packed 7-bit rows; requester i uses bits [7i+6:7i].
REQ-009 SHALL have port req_col  in  21  three packed 7-bit columns; same packing as req_row.
REQ-010 SHALL have port req_wdata  in  96  three packed 32-bit write words.
REQ-011 SHALL have port gnt  out  3  one-hot grant; all zero when idle.
REQ-012 SHALL have port ack  out  3  beat-accepted pulse to the granted requester.
REQ-013 SHALL have port rvalid  out  3  read-data-valid pulse, routed to the requester that issued the read.
REQ-014 SHALL have port rdata  out  32  read data; equals mem_rdata.
REQ-015 SHALL have ports mem_req, mem_rd_wr, mem_tem_win (out, 1 each), mem_row, mem_col (out, 7 each) and mem_wdata (out, 32): the memory command.
REQ-016 SHALL have ports mem_ack (in, 1), mem_rvalid (in, 1) and mem_rdata (in, 32): command accept and in-order read return.
REQ-017 SHALL have port rsp_err  out  1  sticky flag for an unexpected read return.

Function
REQ-018 SHALL implement FSM states IDLE, GRANT and TURN.
REQ-019 IDLE: if any req bit is set, SHALL set gnt for the next cycle and enter GRANT.
- Priority: requester 2 first.
- Otherwise requesters 0 and 1 round-robin; the one not last granted wins; last-granted pointer resets to 1.
REQ-020 GRANT: mem_req SHALL equal req of the granted requester AND NOT (read AND outstanding == MAX_OUTSTANDING).
REQ-021 GRANT: mem_rd_wr, mem_tem_win, mem_row, mem_col and mem_wdata SHALL be combinationally muxed from the granted requester's fields.
REQ-022 A beat SHALL occur when mem_req && mem_ack.
- ack[g] pulses in the same cycle.
- The beat counter increments.
- For a read, the requester ID is pushed into the tag FIFO.
REQ-023 GRANT SHALL exit to TURN when the granted req deasserts, or on the beat that makes the beat counter equal BURST_MAX.
- gnt is cleared on entry to TURN; the beat counter clears.
REQ-024 TURN SHALL last exactly one cycle with mem_req = 0, then return to IDLE; back-to-back grants are therefore separated by at least one idle command cycle.
REQ-025 Read returns: on mem_rvalid with the tag FIFO non-empty, rvalid[head] SHALL pulse in the same cycle and the FIFO pops.
- Return is independent of FSM state; reads complete after the grant is released.
REQ-026 A push and a pop in the same cycle SHALL leave the occupancy unchanged and the FIFO contents correct.
REQ-027 mem_rvalid with an empty FIFO SHALL drive no rvalid bit and set rsp_err, which holds until reset.
REQ-028 Forced release at BURST_MAX with req still high SHALL cause a re-arbitration in IDLE, where a waiting higher or round-robin-favoured requester wins.
REQ-029 Counter widths: the beat counter SHALL be clog2(BURST_MAX+1) bits and the tag FIFO occupancy clog2(MAX_OUTSTANDING+1) bits; neither SHALL wrap.

Reset
REQ-030 rst asserted SHALL immediately force state IDLE; gnt, ack, rvalid and mem_req = 0; beat counter and FIFO empty; rsp_err = 0; round-robin pointer = 1.
REQ-031 Read data returning after a mid-burst reset SHALL be treated as unexpected (REQ-027) and SHALL NOT be routed.

Verification
REQ-032 Single requester: req=3'b001 read, mem_ack held at 1, 5 beats then req drops -> gnt=001 one cycle after req; ack[0] 5 pulses; TURN one cycle; gnt=000.
REQ-033 Contention: req=3'b111 from IDLE -> requester 2 granted first, then 0, then 1 (pointer=1); each grant separated by one mem_req=0 cycle.
REQ-034 Backpressure: MAX_OUTSTANDING=4, mem_rvalid held low, 6 read beats requested -> exactly 4 acks, mem_req low while full; one mem_rvalid -> one more beat issues.
REQ-035 Routing: interleave reads of requester 0 (2 beats) then 1 (2 beats), delayed returns -> rvalid order 001, 001, 010, 010 with matching rdata.
REQ-036 Forced release: BURST_MAX=4, req[0] and req[1] both high continuously -> grants alternate every 4 beats.
REQ-037 Errors: mem_rvalid with empty FIFO -> rsp_err=1 and stays set; rst mid-burst with 2 reads outstanding -> all outputs 0 immediately, later returns set rsp_err without any rvalid.

Source files
------------

// File: rtl/ncc_mem_arbiter.sv
// Three-requester memory arbiter for the NCC engine: writer-first / round-robin grants with burst
// limit, plus an in-order tag FIFO that routes read returns back to the requester that issued them.
module ncc_mem_arbiter #(
    parameter int unsigned BURST_MAX       = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [2:0]  req,
    input  logic [2:0]  req_rd_wr,
    input  logic [2:0]  req_tem_win,
    input  logic [20:0] req_row,
    input  logic [20:0] req_col,
    input  logic [95:0] req_wdata,

    output logic [2:0]  gnt,
    output logic [2:0]  ack,
    output logic [2:0]  rvalid,
    output logic [31:0] rdata,

    output logic        mem_req,
    output logic        mem_rd_wr,
    output logic        mem_tem_win,
    output logic [6:0]  mem_row,
    output logic [6:0]  mem_col,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        rsp_err
);

    localparam int unsigned CntW = $clog2(BURST_MAX + 1);
    localparam int unsigned OccW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    state_e              state_q;
    logic [2:0]          gnt_q;
    logic [CntW-1:0]     beat_cnt_q;
    logic                rr_last_q;   // last granted of requesters 0/1 (0 or 1)

    logic [1:0]          tag_mem_q [MAX_OUTSTANDING];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]     occ_q;
    logic                rsp_err_q;

    logic [1:0]          gidx;
    logic                sel_req, sel_rd_wr, sel_tem_win;
    logic [6:0]          sel_row, sel_col;
    logic [31:0]         sel_wdata;
    logic                in_grant, fifo_full, fifo_empty;
    logic                beat, last_beat, push, pop;
    logic [2:0]          arb_gnt;
    logic [1:0]          head_tag;

    // Granted requester index and its command fields
    always_comb begin
        case (gnt_q)
            3'b010:  gidx = 2'd1;
            3'b100:  gidx = 2'd2;
            default: gidx = 2'd0;
        endcase
    end

    always_comb begin
        sel_req     = 1'b0;
        sel_rd_wr   = 1'b0;
        sel_tem_win = 1'b0;
        sel_row     = '0;
        sel_col     = '0;
        sel_wdata   = '0;
        case (gidx)
            2'd0: begin
                sel_req     = req[0];
                sel_rd_wr   = req_rd_wr[0];
                sel_tem_win = req_tem_win[0];
                sel_row     = req_row[6:0];
                sel_col     = req_col[6:0];
                sel_wdata   = req_wdata[31:0];
            end
            2'd1: begin
                sel_req     = req[1];
                sel_rd_wr   = req_rd_wr[1];
                sel_tem_win = req_tem_win[1];
                sel_row     = req_row[13:7];
                sel_col     = req_col[13:7];
                sel_wdata   = req_wdata[63:32];
            end
            2'd2: begin
                sel_req     = req[2];
                sel_rd_wr   = req_rd_wr[2];
                sel_tem_win = req_tem_win[2];
                sel_row     = req_row[20:14];
                sel_col     = req_col[20:14];
                sel_wdata   = req_wdata[95:64];
            end
            default: ;
        endcase
    end

    assign in_grant   = (state_q == StGrant);
    assign fifo_full  = (occ_q == OccW'(MAX_OUTSTANDING));
    assign fifo_empty = (occ_q == '0);

    // Reads stall while every tag slot is in use; writes are never throttled
    assign mem_req   = in_grant && sel_req && !(!sel_rd_wr && fifo_full);
    assign beat      = mem_req && mem_ack;
    assign last_beat = beat && (beat_cnt_q == CntW'(BURST_MAX - 1));
    assign push      = beat && !sel_rd_wr;
    assign pop       = mem_rvalid && !fifo_empty;

    assign mem_rd_wr   = in_grant ? sel_rd_wr   : 1'b0;
    assign mem_tem_win = in_grant ? sel_tem_win : 1'b0;
    assign mem_row     = in_grant ? sel_row     : '0;
    assign mem_col     = in_grant ? sel_col     : '0;
    assign mem_wdata   = in_grant ? sel_wdata   : '0;

    assign gnt     = gnt_q;
    assign ack     = beat ? gnt_q : 3'b000;
    assign rdata   = mem_rdata;
    assign rsp_err = rsp_err_q;

    // Writer first; readers 0/1 alternate, favouring the one not granted last
    always_comb begin
        arb_gnt = 3'b000;
        if (req[2]) begin
            arb_gnt = 3'b100;
        end else if (req[0] && req[1]) begin
            arb_gnt = rr_last_q ? 3'b001 : 3'b010;
        end else if (req[0]) begin
            arb_gnt = 3'b001;
        end else if (req[1]) begin
            arb_gnt = 3'b010;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= 3'b000;
            beat_cnt_q <= '0;
            rr_last_q  <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req != 3'b000) begin
                        state_q <= StGrant;
                        gnt_q   <= arb_gnt;
                        if (arb_gnt[0]) rr_last_q <= 1'b0;
                        if (arb_gnt[1]) rr_last_q <= 1'b1;
                    end
                end
                StGrant: begin
                    if (!sel_req || last_beat) begin
                        state_q    <= StTurn;
                        gnt_q      <= 3'b000;
                        beat_cnt_q <= '0;
                    end else if (beat) begin
                        beat_cnt_q <= beat_cnt_q + CntW'(1);
                    end
                end
                StTurn: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= 3'b000;
                end
            endcase
        end
    end

    // Tag FIFO: requester IDs of reads in flight, popped in return order
    assign head_tag = tag_mem_q[rd_ptr_q];

    always_comb begin
        rvalid = 3'b000;
        if (pop) begin
            case (head_tag)
                2'd1:    rvalid = 3'b010;
                2'd2:    rvalid = 3'b100;
                default: rvalid = 3'b001;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= gidx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OccW'(1);
                2'b01:   occ_q <= occ_q - OccW'(1);
                default: ;
            endcase
            if (mem_rvalid && fifo_empty) rsp_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ncc_mem_arbiter.sv
// Bench for ncc_mem_arbiter: directed scenarios plus random traffic, all checked cycle by cycle
// against a transaction-level model (grant owner, cooldown, tag queue).
module tb_ncc_mem_arbiter;

    localparam int BM = 6;
    localparam int MO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, req_rd_wr, req_tem_win;
    logic [20:0] req_row, req_col;
    logic [95:0] req_wdata;
    logic [2:0]  gnt, ack, rvalid;
    logic [31:0] rdata;
    logic        mem_req, mem_rd_wr, mem_tem_win;
    logic [6:0]  mem_row, mem_col;
    logic [31:0] mem_wdata;
    logic        mem_ack, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    ncc_mem_arbiter #(.BURST_MAX(BM), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_rd_wr(req_rd_wr), .req_tem_win(req_tem_win),
        .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .gnt(gnt), .ack(ack), .rvalid(rvalid), .rdata(rdata),
        .mem_req(mem_req), .mem_rd_wr(mem_rd_wr), .mem_tem_win(mem_tem_win),
        .mem_row(mem_row), .mem_col(mem_col), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_err(rsp_err)
    );

    // Reference model state
    int owner;      // granted requester, -1 when none
    int beats;      // beats in current grant
    int hold;       // edges to skip before arbitrating again
    int rr_last;    // last granted of readers 0/1
    bit err;
    int tagq[$];

    int tests = 0;
    int fails = 0;

    int ack_cnt[3];
    int gnt_log[$];
    int rv_log[$];
    logic [31:0] rd_log[$];
    logic [2:0] prev_gnt;
    bit auto_ret = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; beats = 0; hold = 0; rr_last = 1; err = 0;
        tagq.delete();
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 3; i++) ack_cnt[i] = 0;
        gnt_log.delete(); rv_log.delete(); rd_log.delete();
        prev_gnt = 3'b000;
    endtask

    task automatic rand_fields();
        req_tem_win = 3'($urandom);
        req_row     = 21'($urandom);
        req_col     = 21'($urandom);
        req_wdata   = {$urandom, $urandom, $urandom};
    endtask

    // One clock cycle: compare outputs at the negedge, advance the model at the posedge
    task automatic step();
        logic [2:0] eg, ea, erv;
        bit emr, full, beat, pop;
        if (auto_ret) begin
            mem_rvalid = (tagq.size() != 0);
            mem_rdata  = $urandom;
        end
        @(negedge clk);
        full = (tagq.size() == MO);
        eg   = (owner >= 0) ? 3'(1 << owner) : 3'b000;
        emr  = (owner >= 0) && req[owner] && !(!req_rd_wr[owner] && full);
        beat = emr && mem_ack;
        ea   = beat ? eg : 3'b000;
        pop  = mem_rvalid && (tagq.size() > 0);
        erv  = pop ? 3'(1 << tagq[0]) : 3'b000;
        check("gnt", gnt, eg);
        check("mem_req", mem_req, emr);
        check("ack", ack, ea);
        check("rvalid", rvalid, erv);
        check("rsp_err", rsp_err, err);
        check("rdata", rdata, mem_rdata);
        if (owner >= 0) begin
            check("mem_cmd", {mem_rd_wr, mem_tem_win, mem_row, mem_col, mem_wdata},
                  {req_rd_wr[owner], req_tem_win[owner], req_row[owner*7 +: 7],
                   req_col[owner*7 +: 7], req_wdata[owner*32 +: 32]});
        end
        for (int i = 0; i < 3; i++) ack_cnt[i] += int'(ack[i]);
        if (gnt != 3'b000 && gnt != prev_gnt) gnt_log.push_back(int'(gnt));
        prev_gnt = gnt;
        if (rvalid != 3'b000) begin
            rv_log.push_back(int'(rvalid));
            rd_log.push_back(rdata);
        end
        @(posedge clk);
        if (mem_rvalid && tagq.size() == 0) err = 1;
        if (pop) void'(tagq.pop_front());
        if (beat && !req_rd_wr[owner]) tagq.push_back(owner);
        if (owner >= 0) begin
            if (!req[owner] || (beat && beats + 1 == BM)) begin
                owner = -1; beats = 0; hold = 1;
            end else if (beat) begin
                beats++;
            end
        end else if (hold > 0) begin
            hold--;
        end else if (req != 3'b000) begin
            if (req[2]) owner = 2;
            else if (req[0] && req[1]) owner = (rr_last == 1) ? 0 : 1;
            else if (req[0]) owner = 0;
            else owner = 1;
            if (owner < 2) rr_last = owner;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000; mem_rvalid = 1'b0; mem_ack = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
    endtask

    task automatic drain();
        auto_ret = 1;
        for (int i = 0; i < 20 && tagq.size() != 0; i++) step();
        auto_ret = 0;
        mem_rvalid = 1'b0;
        check("drain_empty", tagq.size(), 0);
        step();
    endtask

    initial begin
        rst = 1'b1;
        req = '0; req_rd_wr = '0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        rand_fields();
        model_reset();
        clear_logs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        step();
        check("reset_gnt", gnt, 3'b000);
        check("reset_rsp_err", rsp_err, 1'b0);

        // Single reader: 5 beats then release
        clear_logs();
        auto_ret = 1;
        req_rd_wr = 3'b000; mem_ack = 1'b1; req = 3'b001;
        step();
        repeat (5) step();
        req = 3'b000;
        step();
        step();
        check("single_acks", ack_cnt[0], 5);
        check("single_grants", gnt_log.size(), 1);
        check("single_gnt_off", gnt, 3'b000);
        drain();

        // Contention from reset: writer, then 0, then 1
        do_reset();
        req_rd_wr = 3'b111; mem_ack = 1'b1; req = 3'b111;
        for (int i = 0; i < 40 && (req != 3'b000 || owner >= 0); i++) begin
            step();
            for (int k = 0; k < 3; k++) if (ack_cnt[k] >= 2) req[k] = 1'b0;
        end
        check("contend_count", gnt_log.size(), 3);
        if (gnt_log.size() == 3) begin
            check("contend_1st", gnt_log[0], 4);
            check("contend_2nd", gnt_log[1], 1);
            check("contend_3rd", gnt_log[2], 2);
        end

        // Backpressure: tag FIFO fills at MO reads
        step();
        clear_logs();
        req_rd_wr = 3'b000; mem_rvalid = 1'b0; req = 3'b001;
        repeat (10) step();
        check("bp_acks_full", ack_cnt[0], MO);
        check("bp_mem_req_low", mem_req, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        step();
        mem_rvalid = 1'b0;
        repeat (3) step();
        check("bp_one_more", ack_cnt[0], MO + 1);
        req = 3'b000;
        step();
        drain();

        // Routing: two reads from 0, two from 1, delayed returns
        clear_logs();
        req = 3'b001;
        for (int i = 0; i < 10 && ack_cnt[0] < 2; i++) step();
        req = 3'b010;
        for (int i = 0; i < 10 && ack_cnt[1] < 2; i++) step();
        req = 3'b000;
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i);
            step();
        end
        mem_rvalid = 1'b0;
        step();
        check("route_count", rv_log.size(), 4);
        for (int i = 0; i < 4 && i < rv_log.size(); i++) begin
            check("route_id", rv_log[i], (i < 2) ? 1 : 2);
            check("route_data", rd_log[i], 32'hA000_0000 + 32'(i));
        end

        // Forced release at BM beats with both readers holding req (writes keep FIFO out of it)
        do_reset();
        req_rd_wr = 3'b011; mem_ack = 1'b1; req = 3'b011;
        for (int i = 0; i < 100 && gnt_log.size() < 5; i++) step();
        check("forced_count", gnt_log.size(), 5);
        for (int i = 0; i < 5 && i < gnt_log.size(); i++)
            check("forced_alt", gnt_log[i], (i % 2 == 0) ? 1 : 2);
        check("forced_beats0", ack_cnt[0], 2 * BM + 1);
        check("forced_beats1", ack_cnt[1], 2 * BM);

        // Unexpected return sets sticky error
        do_reset();
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        step();
        mem_rvalid = 1'b0;
        repeat (3) step();
        check("err_sticky", rsp_err, 1'b1);

        // Reset mid-burst with reads in flight
        do_reset();
        req_rd_wr = 3'b000; mem_ack = 1'b1; req = 3'b001;
        for (int i = 0; i < 10 && ack_cnt[0] < 2; i++) step();
        check("mid_outstanding", tagq.size(), 2);
        rst = 1'b1;
        #1;
        check("rst_gnt", gnt, 3'b000);
        check("rst_ack", ack, 3'b000);
        check("rst_rvalid", rvalid, 3'b000);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_err", rsp_err, 1'b0);
        model_reset();
        req = 3'b000;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        mem_rvalid = 1'b1;
        repeat (2) step();
        mem_rvalid = 1'b0;
        step();
        check("late_no_rvalid", rv_log.size(), 0);
        check("late_err", rsp_err, 1'b1);

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) req = 3'($urandom);
            if ($urandom_range(0, 7) == 0) req_rd_wr = 3'($urandom);
            mem_ack    = ($urandom_range(0, 3) != 0);
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
            rand_fields();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
